fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Sequences the fetch stage against a variable-latency instruction memory (req/ack).
//  Owns the PC: issues one request at a time, buffers the returned word, and applies
//  branch redirects from execute at any time. Sits between the PC/adder datapath and
//  decode, replacing the single-cycle PCSrc mux/flop path.
// PARAMETERS
//  N         64  PC / address width in bits
//  RESET_PC  0   PC value loaded on reset (N bits)
// PORTS
//  clk            in   1   rising-edge clock, the only clock
//  reset          in   1   asynchronous, active-low reset
//  branch_req     in   1   redirect PC this cycle (PCSrc from execute)
//  branch_target  in   N   redirect address, sampled when branch_req=1
//  stall          in   1   decode not ready; holds the buffered instruction
//  imem_req       out  1   memory request valid
//  imem_addr      out  N   request address, stable while imem_req=1
//  imem_ack       in   1   response valid; one cycle per request, same cycle allowed
//  imem_rdata     in   32  instruction word, valid when imem_ack=1
//  instr_valid    out  1   instr/instr_pc hold a live instruction
//  instr          out  32  buffered instruction
//  instr_pc       out  N   address instr was fetched from
// BEHAVIOUR
//  Reset (async, reset=0): state=IDLE, pc=RESET_PC, req_addr=0, imem_req=0,
//   instr_valid=0, instr=0, instr_pc=0. Any in-flight access is abandoned; the memory
//   shares this reset.
//  Handshake: once imem_req rises it stays high with imem_addr constant until the ack
//   cycle. The ack cycle completes the request. imem_req is a decode of state REQ/DISCARD.
//   imem_addr=req_addr.
//  Consume: instr_valid=1 && stall=0 in a cycle -> that instruction is taken by decode.
//  States:
//   IDLE    -> REQ next cycle. req_addr<=pc, or branch_target if branch_req.
//   REQ     ack, no branch: instr<=imem_rdata, instr_pc<=req_addr, instr_valid<=1,
//            pc<=req_addr+4 (wraps mod 2^N) -> HOLD.
//           branch, no ack: pc<=branch_target -> DISCARD.
//           branch and ack same cycle: data dropped, req_addr<=branch_target -> REQ.
//   HOLD    consume and no branch: instr_valid<=0, req_addr<=pc -> REQ.
//           stall: hold all outputs.
//           branch (overrides stall): instr_valid<=0, req_addr<=branch_target -> REQ.
//   DISCARD waits for the old request's ack; its data is never buffered.
//           ack: req_addr<=pc, or branch_target if branch_req -> REQ.
//           branch without ack: pc<=branch_target, stay.
//  A branch always flushes instr_valid (0 next cycle), including from IDLE.
//  Throughput: zero-wait memory, no stall -> one instruction every 2 cycles.
//  Latency: REQ entry to instr_valid = ack latency + 1 cycle.
//  All outputs are registered, with no combinational input->output paths; imem_req is
//   a decode of registered state.
// STRUCTURE
//  fetch_pkg: typedef enum logic [1:0] {IDLE, REQ, HOLD, DISCARD} fetch_state_t;
//   localparam INSTR_W=32, PC_INC=4.
//  One sub-module: fetch_ibuf (instr/instr_pc/instr_valid holding register with load,
//   clear and async active-low reset). PC increment reuses the existing adder.
// TESTING
//  1 Reset, RESET_PC=0x100, ack 1 cycle after req, stall=0 -> imem_addr 0x100,0x104,0x108.
//    instr_valid pulses every 2nd cycle; instr_pc matches.
//  2 stall=1 for 5 cycles while HOLD -> instr/instr_pc unchanged, imem_req=0.
//    Release -> next req addr=instr_pc+4.
//  3 branch_req (target 0x400) while REQ, ack 3 cycles later -> data 0xDEADBEEF dropped.
//    Next req addr=0x400; instr_valid never shows the stale word.
//  4 branch_req and imem_ack same cycle -> ack data dropped; next cycle imem_req=1 at target.
//  5 Two branches during DISCARD (0x200 then 0x300) -> first request after ack is 0x300.
//  6 reset=0 mid-REQ -> all outputs 0 immediately (async).
//    After release, fetch restarts at RESET_PC.
//  Checks at every cycle: imem_addr stable while imem_req=1; PC wrap 2^N-4 -> 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer slice.
// State encoding of the request FSM plus instruction width and PC step.
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, REQ, HOLD, DISCARD} fetch_state_t;
  localparam int INSTR_W = 32;
  localparam int PC_INC  = 4;
endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle: branch redirect and decode stall in, imem req/ack, buffered instruction out.
// master = fetch_sequencer, slave = surrounding pipeline and instruction memory.
interface fetch_sequencer_if #(parameter int N = 64);
  import fetch_pkg::*;

  logic               branch_req;
  logic [N-1:0]       branch_target;
  logic               stall;
  logic               imem_req;
  logic [N-1:0]       imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [N-1:0]       instr_pc;

  modport master (
    input  branch_req, branch_target, stall, imem_ack, imem_rdata,
    output imem_req, imem_addr, instr_valid, instr, instr_pc
  );

  modport slave (
    output branch_req, branch_target, stall, imem_ack, imem_rdata,
    input  imem_req, imem_addr, instr_valid, instr, instr_pc
  );
endinterface

// File: rtl/fetch_ibuf.sv
// Holding register for one fetched instruction and its PC; 1-cycle load, clear beats load.
// Contents persist until cleared, which is how a decode stall is absorbed.
module fetch_ibuf import fetch_pkg::*; #(
  parameter int N = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_vld,
  input  logic               clear,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [N-1:0]       load_pc,
  output logic               instr_vld,
  output logic [INSTR_W-1:0] instr,
  output logic [N-1:0]       instr_pc
);
  logic               vld_q, vld_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [N-1:0]       pc_q, pc_d;

  // Clearing only drops the valid bit; the stale word is never observed while invalid.
  always_comb begin
    vld_d   = vld_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (clear) begin
      vld_d = 1'b0;
    end else if (load_vld) begin
      vld_d   = 1'b1;
      instr_d = load_instr;
      pc_d    = load_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      vld_q   <= vld_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign instr_vld = vld_q;
  assign instr     = instr_q;
  assign instr_pc  = pc_q;
endmodule

// File: rtl/fetch_sequencer.sv
// Owns the PC and runs one imem request at a time; instr_valid arrives ack latency + 1 after REQ entry.
// Decode stall holds the buffered word; branches flush it and redirect at any time, all outputs registered.
module fetch_sequencer import fetch_pkg::*; #(
  parameter int           N        = 64,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  fetch_sequencer_if.master bus
);
  fetch_state_t state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic [N-1:0] req_addr_q, req_addr_d;
  logic [N-1:0] pc_inc;
  logic         ibuf_load;
  logic         ibuf_clear;
  logic         ibuf_vld;
  logic [INSTR_W-1:0] ibuf_instr;
  logic [N-1:0] ibuf_pc;

  assign pc_inc = req_addr_q + N'(PC_INC);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    ibuf_load  = 1'b0;
    ibuf_clear = bus.branch_req;
    case (state_q)
      IDLE: begin
        state_d    = REQ;
        req_addr_d = bus.branch_req ? bus.branch_target : pc_q;
      end
      REQ: begin
        if (bus.imem_ack && !bus.branch_req) begin
          ibuf_load = 1'b1;
          pc_d      = pc_inc;
          state_d   = HOLD;
        end else if (bus.branch_req && !bus.imem_ack) begin
          pc_d    = bus.branch_target;
          state_d = DISCARD;
        end else if (bus.branch_req && bus.imem_ack) begin
          // Request is complete but redirected; reissue straight at the target.
          req_addr_d = bus.branch_target;
        end
      end
      HOLD: begin
        if (bus.branch_req) begin
          req_addr_d = bus.branch_target;
          state_d    = REQ;
        end else if (!bus.stall) begin
          ibuf_clear = 1'b1;
          req_addr_d = pc_q;
          state_d    = REQ;
        end
      end
      DISCARD: begin
        // The old request must still complete before a new address may be presented.
        if (bus.imem_ack) begin
          req_addr_d = bus.branch_req ? bus.branch_target : pc_q;
          state_d    = REQ;
        end else if (bus.branch_req) begin
          pc_d = bus.branch_target;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  fetch_ibuf #(.N(N)) u_ibuf (
    .clk        (clk),
    .rst_n      (reset),
    .load_vld   (ibuf_load),
    .clear      (ibuf_clear),
    .load_instr (bus.imem_rdata),
    .load_pc    (req_addr_q),
    .instr_vld  (ibuf_vld),
    .instr      (ibuf_instr),
    .instr_pc   (ibuf_pc)
  );

  assign bus.imem_req    = (state_q == REQ) || (state_q == DISCARD);
  assign bus.imem_addr   = req_addr_q;
  assign bus.instr_valid = ibuf_vld;
  assign bus.instr       = ibuf_instr;
  assign bus.instr_pc    = ibuf_pc;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: latency-programmable imem model, scoreboard of expected
// (pc, word) pairs consumed by decode, and per-scenario inline checks.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  localparam int           N      = 64;
  localparam logic [N-1:0] RST_PC = 64'h100;

  typedef struct packed {
    logic [N-1:0] pc;
    logic [31:0]  w;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  int   mem_lat = 0;
  int   mem_cnt = 0;
  bit   mem_force = 1'b0;
  exp_t sb[$];
  bit           prev_pending = 1'b0;
  logic [N-1:0] prev_addr = '0;

  fetch_sequencer_if #(.N(N)) ifc();

  fetch_sequencer #(.N(N), .RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [N-1:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  // Memory model: acks a request after mem_lat waiting cycles; advances to the next negedge.
  task automatic step();
    if (ifc.imem_req === 1'b1) begin
      if (mem_cnt >= mem_lat) begin
        ifc.imem_ack   = 1'b1;
        ifc.imem_rdata = mem_force ? 32'hDEAD_BEEF : mem_word(ifc.imem_addr);
        mem_cnt        = 0;
      end else begin
        ifc.imem_ack = 1'b0;
        mem_cnt++;
      end
    end else begin
      ifc.imem_ack = 1'b0;
      mem_cnt      = 0;
    end
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [N-1:0] pc);
    exp_t e;
    e.pc = pc;
    e.w  = mem_word(pc);
    sb.push_back(e);
  endtask

  task automatic do_reset();
    reset             = 1'b0;
    ifc.branch_req    = 1'b0;
    ifc.branch_target = '0;
    ifc.stall         = 1'b0;
    ifc.imem_ack      = 1'b0;
    ifc.imem_rdata    = '0;
    mem_cnt           = 0;
    mem_force         = 1'b0;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Every-cycle checks: address stability during a pending request, and scoreboard on consume.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (reset !== 1'b1) begin
      prev_pending = 1'b0;
    end else begin
      if (prev_pending && ifc.imem_req === 1'b1) begin
        n_vec++;
        if (ifc.imem_addr !== prev_addr) begin
          n_err++;
          $display("FAIL addr_stable: imem_addr=%h while request to %h pending", ifc.imem_addr, prev_addr);
        end
      end
      prev_pending = (ifc.imem_req === 1'b1) && (ifc.imem_ack !== 1'b1);
      prev_addr    = ifc.imem_addr;
      if (ifc.instr_valid === 1'b1 && ifc.stall === 1'b0) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected: consumed pc=%h instr=%h, none expected", ifc.instr_pc, ifc.instr);
        end else begin
          e = sb.pop_front();
          if (ifc.instr_pc !== e.pc || ifc.instr !== e.w) begin
            n_err++;
            $display("FAIL sb_data: got pc=%h instr=%h, want pc=%h instr=%h", ifc.instr_pc, ifc.instr, e.pc, e.w);
          end
        end
      end
    end
  end

  task automatic test_reset();
    mem_lat = 0;
    reset = 1'b0;
    ifc.branch_req = 1'b0; ifc.branch_target = '0; ifc.stall = 1'b0;
    ifc.imem_ack = 1'b0; ifc.imem_rdata = '0; mem_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    n_vec++; if (ifc.imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", ifc.imem_req); end
    n_vec++; if (ifc.imem_addr !== '0) begin n_err++; $display("FAIL rst_addr: got %h want 0", ifc.imem_addr); end
    n_vec++; if (ifc.instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", ifc.instr_valid); end
    n_vec++; if (ifc.instr !== '0) begin n_err++; $display("FAIL rst_instr: got %h want 0", ifc.instr); end
    n_vec++; if (ifc.instr_pc !== '0) begin n_err++; $display("FAIL rst_pc: got %h want 0", ifc.instr_pc); end
    reset = 1'b1;
    step();
    n_vec++;
    if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== RST_PC) begin
      n_err++; $display("FAIL rst_first_req: got req=%b addr=%h want req=1 addr=%h", ifc.imem_req, ifc.imem_addr, RST_PC);
    end
  endtask

  task automatic test_stream();
    mem_lat = 0;
    do_reset();
    push_exp(RST_PC); push_exp(RST_PC + 64'd4); push_exp(RST_PC + 64'd8);
    for (int i = 0; i < 7; i++) begin
      n_vec++;
      if (ifc.imem_req !== (i % 2 == 1)) begin n_err++; $display("FAIL stream_req[%0d]: got %b", i, ifc.imem_req); end
      n_vec++;
      if (ifc.instr_valid !== (i >= 2 && i % 2 == 0)) begin n_err++; $display("FAIL stream_valid[%0d]: got %b", i, ifc.instr_valid); end
      if (i % 2 == 1) begin
        n_vec++;
        if (ifc.imem_addr !== RST_PC + 64'(4 * ((i - 1) / 2))) begin
          n_err++; $display("FAIL stream_addr[%0d]: got %h want %h", i, ifc.imem_addr, RST_PC + 64'(4 * ((i - 1) / 2)));
        end
      end
      if (i < 6) step();
    end
    #2;
    n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL stream_drain: %0d left, want 0", sb.size()); end
  endtask

  task automatic test_stall();
    mem_lat = 0;
    do_reset();
    push_exp(RST_PC);
    step(); step();
    ifc.stall = 1'b1;
    n_vec++; if (ifc.instr_valid !== 1'b1) begin n_err++; $display("FAIL stall_hold_entry: valid=%b want 1", ifc.instr_valid); end
    repeat (5) begin
      step();
      n_vec++;
      if (ifc.instr_valid !== 1'b1 || ifc.instr !== mem_word(RST_PC) || ifc.instr_pc !== RST_PC || ifc.imem_req !== 1'b0) begin
        n_err++;
        $display("FAIL stall_hold: valid=%b instr=%h pc=%h req=%b want 1 %h %h 0",
                 ifc.instr_valid, ifc.instr, ifc.instr_pc, ifc.imem_req, mem_word(RST_PC), RST_PC);
      end
    end
    push_exp(RST_PC + 64'd4);
    ifc.stall = 1'b0;
    step();
    n_vec++;
    if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== RST_PC + 64'd4) begin
      n_err++; $display("FAIL stall_release: req=%b addr=%h want 1 %h", ifc.imem_req, ifc.imem_addr, RST_PC + 64'd4);
    end
    step();
    n_vec++; if (ifc.instr_valid !== 1'b1) begin n_err++; $display("FAIL stall_next_valid: got %b want 1", ifc.instr_valid); end
    #2;
    n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL stall_drain: %0d left, want 0", sb.size()); end
  endtask

  task automatic test_branch_in_req();
    bit seen;
    mem_lat = 3;
    do_reset();
    mem_force = 1'b1;
    step();
    ifc.branch_req = 1'b1; ifc.branch_target = 64'h400;
    step();
    ifc.branch_req = 1'b0;
    n_vec++;
    if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== RST_PC) begin
      n_err++; $display("FAIL br_discard_addr: req=%b addr=%h want 1 %h", ifc.imem_req, ifc.imem_addr, RST_PC);
    end
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      n_vec++;
      if (ifc.instr_valid !== 1'b0) begin n_err++; $display("FAIL br_no_stale: valid=%b instr=%h want valid 0", ifc.instr_valid, ifc.instr); end
      step();
      if (ifc.imem_req === 1'b1 && ifc.imem_addr === 64'h400) seen = 1'b1;
    end
    n_vec++; if (!seen) begin n_err++; $display("FAIL br_new_req: addr=%h want 400 within 10 cycles", ifc.imem_addr); end
    mem_force = 1'b0;
    push_exp(64'h400);
    for (int k = 0; k < 10 && ifc.instr_valid !== 1'b1; k++) step();
    n_vec++;
    if (ifc.instr_valid !== 1'b1 || ifc.instr === 32'hDEAD_BEEF || ifc.instr_pc !== 64'h400) begin
      n_err++; $display("FAIL br_target_instr: valid=%b instr=%h pc=%h want 1 %h 400", ifc.instr_valid, ifc.instr, ifc.instr_pc, mem_word(64'h400));
    end
    #2;
    n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL br_drain: %0d left, want 0", sb.size()); end
  endtask

  task automatic test_branch_with_ack();
    mem_lat = 0;
    do_reset();
    step();
    ifc.branch_req = 1'b1; ifc.branch_target = 64'h500;
    step();
    ifc.branch_req = 1'b0;
    n_vec++;
    if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 64'h500 || ifc.instr_valid !== 1'b0) begin
      n_err++; $display("FAIL bra_redirect: req=%b addr=%h valid=%b want 1 500 0", ifc.imem_req, ifc.imem_addr, ifc.instr_valid);
    end
    push_exp(64'h500);
    step();
    n_vec++;
    if (ifc.instr_valid !== 1'b1 || ifc.instr_pc !== 64'h500) begin
      n_err++; $display("FAIL bra_target: valid=%b pc=%h want 1 500", ifc.instr_valid, ifc.instr_pc);
    end
    push_exp(64'h504);
    step();
    n_vec++;
    if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 64'h504) begin
      n_err++; $display("FAIL bra_seq: req=%b addr=%h want 1 504", ifc.imem_req, ifc.imem_addr);
    end
    step();
    #2;
    n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL bra_drain: %0d left, want 0", sb.size()); end
  endtask

  task automatic test_discard_branches();
    mem_lat = 4;
    do_reset();
    step();
    ifc.branch_req = 1'b1; ifc.branch_target = 64'h180; step();
    ifc.branch_target = 64'h200; step();
    ifc.branch_target = 64'h300; step();
    ifc.branch_req = 1'b0;
    n_vec++;
    if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== RST_PC || ifc.instr_valid !== 1'b0) begin
      n_err++; $display("FAIL dis_hold: req=%b addr=%h valid=%b want 1 %h 0", ifc.imem_req, ifc.imem_addr, ifc.instr_valid, RST_PC);
    end
    for (int k = 0; k < 8 && !(ifc.imem_req === 1'b1 && ifc.imem_addr !== RST_PC); k++) step();
    n_vec++;
    if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 64'h300) begin
      n_err++; $display("FAIL dis_last_target: req=%b addr=%h want 1 300", ifc.imem_req, ifc.imem_addr);
    end
    push_exp(64'h300);
    for (int k = 0; k < 10 && ifc.instr_valid !== 1'b1; k++) step();
    n_vec++; if (ifc.instr_valid !== 1'b1) begin n_err++; $display("FAIL dis_valid: got %b want 1", ifc.instr_valid); end
    #2;
    n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL dis_drain: %0d left, want 0", sb.size()); end
  endtask

  task automatic test_async_reset();
    mem_lat = 2;
    do_reset();
    step();
    n_vec++; if (ifc.imem_req !== 1'b1) begin n_err++; $display("FAIL ar_in_req: req=%b want 1", ifc.imem_req); end
    #2;
    reset = 1'b0;
    #1;
    n_vec++;
    if (ifc.imem_req !== 1'b0 || ifc.imem_addr !== '0 || ifc.instr_valid !== 1'b0 || ifc.instr !== '0 || ifc.instr_pc !== '0) begin
      n_err++; $display("FAIL ar_outputs: req=%b addr=%h valid=%b instr=%h pc=%h want all 0",
                        ifc.imem_req, ifc.imem_addr, ifc.instr_valid, ifc.instr, ifc.instr_pc);
    end
    ifc.imem_ack = 1'b0; mem_cnt = 0; sb.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    push_exp(RST_PC);
    step();
    n_vec++;
    if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== RST_PC) begin
      n_err++; $display("FAIL ar_restart: req=%b addr=%h want 1 %h", ifc.imem_req, ifc.imem_addr, RST_PC);
    end
    for (int k = 0; k < 10 && ifc.instr_valid !== 1'b1; k++) step();
    n_vec++; if (ifc.instr_valid !== 1'b1) begin n_err++; $display("FAIL ar_valid: got %b want 1", ifc.instr_valid); end
    #2;
    n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL ar_drain: %0d left, want 0", sb.size()); end
  endtask

  task automatic test_pc_wrap();
    mem_lat = 0;
    do_reset();
    step();
    ifc.branch_req = 1'b1; ifc.branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    ifc.branch_req = 1'b0;
    n_vec++;
    if (ifc.imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_err++; $display("FAIL wrap_top: addr=%h want fffffffffffffffc", ifc.imem_addr); end
    push_exp(64'hFFFF_FFFF_FFFF_FFFC);
    step();
    push_exp(64'h0);
    step();
    n_vec++;
    if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 64'h0) begin
      n_err++; $display("FAIL wrap_zero: req=%b addr=%h want 1 0", ifc.imem_req, ifc.imem_addr);
    end
    step();
    #2;
    n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL wrap_drain: %0d left, want 0", sb.size()); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: still running at %0t, limit 100000", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_branch_in_req();
    test_branch_with_ack();
    test_discard_branches();
    test_async_reset();
    test_pc_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
